// File: rtl/sar_search_nb_pkg.sv
// Shared types for successive-approximation sequencers: FSM state encoding and
// comparator flag resolution (eq > gt > lt, silent comparator treated as lt).
package sar_search_nb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TEST = 2'd1,
    ST_DONE = 2'd2
  } sar_state_e;

  typedef enum logic [1:0] {
    FLAG_NONE = 2'd0,
    FLAG_LT   = 2'd1,
    FLAG_GT   = 2'd2,
    FLAG_EQ   = 2'd3
  } sar_flag_e;

  function automatic sar_flag_e resolve_flags(input logic eq, input logic lt, input logic gt);
    sar_flag_e f;
    f = FLAG_NONE;
    if (eq)      f = FLAG_EQ;
    else if (gt) f = FLAG_GT;
    else if (lt) f = FLAG_LT;
    return f;
  endfunction

  // A zero-cycle settle still needs a 1-bit counter to keep port widths legal.
  function automatic int unsigned cnt_width(input int unsigned settle);
    return (settle == 0) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/sar_search_nb_settle_cnt.sv
// Loadable settle down-counter; zero flag marks when comparator flags may be sampled.
module sar_search_nb_settle_cnt
  import sar_search_nb_pkg::*;
#(
  parameter int unsigned SETTLE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int unsigned CW = cnt_width(SETTLE);
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sar_search_nb.sv
// Successive-approximation search controller: presents trial operands to an external
// magnitude comparator and resolves the unknown operand MSB first.
module sar_search_nb
  import sar_search_nb_pkg::*;
#(
  parameter int unsigned n      = 8,
  parameter int unsigned SETTLE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         cmp_eq,
  input  logic         cmp_lt,
  input  logic         cmp_gt,
  output logic [n-1:0] trial,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] result,
  output logic         exact
);

  localparam int unsigned KW = $clog2(n);
  localparam logic [KW-1:0] K_MSB = KW'(n - 1);

  sar_state_e    state, state_n;
  logic [n-1:0]  accum, accum_n;
  logic [n-1:0]  trial_n, result_n;
  logic [KW-1:0] k, k_n;
  logic          busy_n, done_n, exact_n;
  logic          cnt_load, cnt_dec, settled;
  sar_flag_e     flag;

  sar_search_nb_settle_cnt #(.SETTLE(SETTLE)) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .zero  (settled)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      accum  <= '0;
      k      <= '0;
      trial  <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      exact  <= 1'b0;
    end else begin
      state  <= state_n;
      accum  <= accum_n;
      k      <= k_n;
      trial  <= trial_n;
      result <= result_n;
      busy   <= busy_n;
      done   <= done_n;
      exact  <= exact_n;
    end
  end

  // trial is registered: it is precomputed as accum | (1<<k) for the next bit so
  // the comparator sees it for the whole settle window.
  always_comb begin
    state_n  = state;
    accum_n  = accum;
    k_n      = k;
    trial_n  = trial;
    result_n = result;
    busy_n   = busy;
    done_n   = 1'b0;
    exact_n  = exact;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    flag     = resolve_flags(cmp_eq, cmp_lt, cmp_gt);

    case (state)
      ST_IDLE: begin
        trial_n = '0;
        busy_n  = 1'b0;
        if (start) begin
          accum_n        = '0;
          k_n            = K_MSB;
          cnt_load       = 1'b1;
          trial_n[n-1]   = 1'b1;
          busy_n         = 1'b1;
          state_n        = ST_TEST;
        end
      end

      ST_TEST: begin
        if (!settled) begin
          cnt_dec = 1'b1;
        end else begin
          if ((flag == FLAG_EQ) || (flag == FLAG_GT)) begin
            accum_n = trial;
          end
          if (flag == FLAG_EQ) begin
            result_n = trial;
            exact_n  = 1'b1;
            state_n  = ST_DONE;
          end else if (k == '0) begin
            result_n = accum_n;
            exact_n  = 1'b0;
            state_n  = ST_DONE;
          end else begin
            k_n          = k - KW'(1);
            cnt_load     = 1'b1;
            trial_n      = accum_n;
            trial_n[k_n] = 1'b1;
          end
          if (state_n == ST_DONE) begin
            trial_n = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end

      ST_DONE: begin
        trial_n = '0;
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end

      default: begin
        trial_n = '0;
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sar_search_nb.sv
// Scoreboarded bench: two controllers (SETTLE=0 and SETTLE=3 with delayed flags)
// each paired with a behavioural comparator around a hidden operand.
module tb_sar_search_nb;

  localparam int M_NORMAL   = 0;
  localparam int M_NEVER_EQ = 1;
  localparam int M_EQ_GT    = 2;
  localparam int M_SILENT   = 3;

  typedef struct {
    logic [7:0]  res;
    logic        ex;
    int unsigned due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0;
  int errors = 0;

  logic       rst0_n, start0, eq0, lt0, gt0, busy0, done0, exact0;
  logic [7:0] trial0, result0, a0;
  int         mode0;
  logic       rst3_n, start3, eq3, lt3, gt3, busy3, done3, exact3;
  logic [7:0] trial3, result3, a3;
  int         mode3;
  logic [2:0] raw3, d3_1 = '0, d3_2 = '0, d3_3 = '0;

  exp_t       exp0_q[$], exp3_q[$];
  logic [7:0] tq0[$], tq3[$];

  sar_search_nb #(.n(8), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .start(start0),
    .cmp_eq(eq0), .cmp_lt(lt0), .cmp_gt(gt0),
    .trial(trial0), .busy(busy0), .done(done0), .result(result0), .exact(exact0)
  );

  sar_search_nb #(.n(8), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .start(start3),
    .cmp_eq(eq3), .cmp_lt(lt3), .cmp_gt(gt3),
    .trial(trial3), .busy(busy3), .done(done3), .result(result3), .exact(exact3)
  );

  // returns {eq, lt, gt}
  function automatic logic [2:0] cmp_model(input logic [7:0] a, input logic [7:0] t, input int mode);
    logic [2:0] f;
    f = 3'b000;
    case (mode)
      M_NORMAL:   f = {a == t, a < t, a > t};
      M_NEVER_EQ: f = {1'b0, a < t, a >= t};
      M_EQ_GT:    f = {a == t, a < t, a >= t};
      default:    f = 3'b000;
    endcase
    return f;
  endfunction

  always_comb {eq0, lt0, gt0} = cmp_model(a0, trial0, mode0);

  // three-cycle comparator latency in front of the SETTLE=3 instance
  always_comb raw3 = cmp_model(a3, trial3, mode3);
  always @(posedge clk) begin
    d3_1 <= raw3;
    d3_2 <= d3_1;
    d3_3 <= d3_2;
  end
  always_comb {eq3, lt3, gt3} = d3_3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s done pulse with no run pending (cycle %0d)", name, cycle);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (busy0 && tq0.size() > 0) check("trial0", {24'd0, trial0}, {24'd0, tq0.pop_front()});
    if (busy3 && tq3.size() > 0) check("trial3", {24'd0, trial3}, {24'd0, tq3.pop_front()});
    if (done0) begin
      if (exp0_q.size() == 0) unexpected("done0");
      else begin
        e = exp0_q.pop_front();
        check("result0", {24'd0, result0}, {24'd0, e.res});
        check("exact0", {31'd0, exact0}, {31'd0, e.ex});
        check("latency0", cycle, e.due);
        check("idle_outs0", {23'd0, busy0, trial0}, 32'd0);
      end
    end
    if (done3) begin
      if (exp3_q.size() == 0) unexpected("done3");
      else begin
        e = exp3_q.pop_front();
        check("result3", {24'd0, result3}, {24'd0, e.res});
        check("exact3", {31'd0, exact3}, {31'd0, e.ex});
        check("latency3", cycle, e.due);
        check("idle_outs3", {23'd0, busy3, trial3}, 32'd0);
      end
    end
  end

  task automatic push_tr(input int which, input logic [7:0] t[8], input int cnt, input int rep);
    for (int i = 0; i < cnt; i++)
      for (int r = 0; r < rep; r++)
        if (which == 0) tq0.push_back(t[i]);
        else            tq3.push_back(t[i]);
  endtask

  task automatic go0(input logic [7:0] a, input int mode, input logic [7:0] res,
                     input logic ex, input int unsigned lat);
    exp_t e;
    @(negedge clk);
    a0 = a; mode0 = mode; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    e.res = res; e.ex = ex; e.due = cycle + lat - 1;
    exp0_q.push_back(e);
  endtask

  task automatic go3(input logic [7:0] a, input int mode, input logic [7:0] res,
                     input logic ex, input int unsigned lat);
    exp_t e;
    @(negedge clk);
    a3 = a; mode3 = mode; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    e.res = res; e.ex = ex; e.due = cycle + lat - 1;
    exp3_q.push_back(e);
  endtask

  task automatic wait0();
    int unsigned guard = 0;
    while (exp0_q.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    if (exp0_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout0 pending=%0d required=0", exp0_q.size());
      exp0_q.delete();
    end
    check("trials_left0", tq0.size(), 0);
    tq0.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic wait3();
    int unsigned guard = 0;
    while (exp3_q.size() != 0 && guard < 400) begin
      @(posedge clk);
      guard++;
    end
    if (exp3_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout3 pending=%0d required=0", exp3_q.size());
      exp3_q.delete();
    end
    check("trials_left3", tq3.size(), 0);
    tq3.delete();
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq[8];
    exp_t e;
    int unsigned sc;

    rst0_n = 1'b0; rst3_n = 1'b0; start0 = 1'b0; start3 = 1'b0;
    a0 = '0; a3 = '0; mode0 = M_NORMAL; mode3 = M_NORMAL;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset0", {7'd0, trial0, busy0, done0, result0, exact0}, 32'd0);
    check("reset3", {7'd0, trial3, busy3, done3, result3, exact3}, 32'd0);
    rst0_n = 1'b1; rst3_n = 1'b1;
    repeat (2) @(posedge clk);

    // exact hit on the last bit
    seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    push_tr(0, seq, 8, 1);
    go0(8'hA5, M_NORMAL, 8'hA5, 1'b1, 9); wait0();

    // extremes
    go0(8'h80, M_NORMAL, 8'h80, 1'b1, 2); wait0();
    go0(8'h00, M_NORMAL, 8'h00, 1'b0, 9); wait0();
    go0(8'hFF, M_NORMAL, 8'hFF, 1'b1, 9); wait0();
    go0(8'hFE, M_NEVER_EQ, 8'hFE, 1'b0, 9); wait0();

    // settle window with delayed flags
    seq = '{8'h80, 8'h40, 8'h20, 8'h30, 8'h38, 8'h3C, 8'h3E, 8'h3D};
    push_tr(1, seq, 8, 4);
    go3(8'h3C, M_NEVER_EQ, 8'h3C, 1'b0, 33); wait3();
    go3(8'h80, M_NORMAL, 8'h80, 1'b1, 5); wait3();

    // reset during the 4th TEST cycle aborts with no done
    @(negedge clk);
    a0 = 8'hA5; mode0 = M_NORMAL; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst0_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_outs0", {14'd0, trial0, busy0, done0, result0, exact0}, 32'd0);
    rst0_n = 1'b1;
    repeat (12) @(posedge clk);
    seq = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h00};
    push_tr(0, seq, 7, 1);
    go0(8'h5A, M_NORMAL, 8'h5A, 1'b1, 8); wait0();

    // start pulse while busy is ignored
    seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    push_tr(0, seq, 8, 1);
    go0(8'hA5, M_NORMAL, 8'hA5, 1'b1, 9);
    repeat (2) @(posedge clk);
    #1 start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    wait0();

    // eq together with gt resolves as eq; silent comparator clears every bit
    go0(8'hC0, M_EQ_GT, 8'hC0, 1'b1, 3); wait0();
    go0(8'hA5, M_SILENT, 8'h00, 1'b0, 9); wait0();

    // start held high: DONE ignores it, the following IDLE launches a new run
    @(negedge clk);
    a0 = 8'h80; mode0 = M_NORMAL; start0 = 1'b1;
    @(posedge clk); #1;
    sc = cycle;
    e.res = 8'h80; e.ex = 1'b1; e.due = sc + 1; exp0_q.push_back(e);
    e.due = sc + 4; exp0_q.push_back(e);
    repeat (3) @(posedge clk);
    #1 start0 = 1'b0;
    wait0();
    repeat (6) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
